// File: rtl/sysdefs_pkg.sv
// Shared solver definitions: index width default, backtrack FSM states and
// the trace entry type encoding used by every block that touches the trace.
package sysdefs_pkg;

   localparam int MAX_VARS_BITS_DFLT = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SCAN = 3'd1,
      FLIP = 3'd2,
      DONE = 3'd3,
      FAIL = 3'd4
   } bt_state_t;

   typedef enum logic {
      ENTRY_DECIDE = 1'b0,
      ENTRY_FORCED = 1'b1
   } entry_type_t;

endpackage

// File: rtl/backtrack_unit.sv
// Conflict backtracker: unwinds forced trace entries down to the newest
// decision, then re-asserts that decision inverted as a forced entry.
module backtrack_unit
   import sysdefs_pkg::*;
#(
   parameter int MAX_VARS_BITS = MAX_VARS_BITS_DFLT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     unsat,
   input  logic                     trace_empty,
   input  logic                     trace_type,
   input  logic                     trace_val,
   input  logic [MAX_VARS_BITS-1:0] trace_var,
   output logic                     trace_pop,
   output logic                     trace_push,
   output logic                     trace_type_out,
   output logic                     trace_val_out,
   output logic [MAX_VARS_BITS-1:0] trace_var_out,
   output logic                     vs_write,
   output logic                     vs_val,
   output logic                     vs_unassign,
   output logic [MAX_VARS_BITS-1:0] vs_var,
   input  logic                     ds_empty,
   input  logic [MAX_VARS_BITS-1:0] ds_dec_idx,
   output logic                     ds_pop,
   output logic                     dec_write,
   output logic [MAX_VARS_BITS-1:0] dec_back_idx,
   output logic                     imply_clear,
   output logic [MAX_VARS_BITS:0]   pop_count
);

   localparam logic [MAX_VARS_BITS:0] POP_ONE = 1;
   localparam logic [MAX_VARS_BITS:0] POP_MAX = '1;

   bt_state_t                state;
   logic [MAX_VARS_BITS-1:0] lat_var;
   logic                     lat_val;

   // busy/done/unsat are flops so they never glitch with the stack inputs.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         unsat     <= 1'b0;
         pop_count <= '0;
         lat_var   <= '0;
         lat_val   <= 1'b0;
      end else begin
         done  <= 1'b0;
         unsat <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN;
                  busy      <= 1'b1;
                  pop_count <= '0;
               end
            end
            SCAN: begin
               if (trace_empty) begin
                  state <= FAIL;
                  done  <= 1'b1;
                  unsat <= 1'b1;
               end else begin
                  if (pop_count != POP_MAX)
                     pop_count <= pop_count + POP_ONE;
                  if (entry_type_t'(trace_type) == ENTRY_DECIDE) begin
                     lat_var <= trace_var;
                     lat_val <= trace_val;
                     state   <= FLIP;
                  end
               end
            end
            FLIP: begin
               done <= 1'b1;
               if (ds_empty) begin
                  state <= FAIL;
                  unsat <= 1'b1;
               end else begin
                  state <= DONE;
               end
            end
            DONE, FAIL: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Stack and var_state strobes act on the current top, so they are
   // decoded combinationally from state and the stack inputs.
   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      imply_clear    = 1'b0;
      trace_pop      = 1'b0;
      trace_push     = 1'b0;
      trace_type_out = 1'b0;
      trace_val_out  = 1'b0;
      trace_var_out  = '0;
      vs_write       = 1'b0;
      vs_val         = 1'b0;
      vs_unassign    = 1'b0;
      vs_var         = '0;
      ds_pop         = 1'b0;
      dec_write      = 1'b0;
      dec_back_idx   = '0;
      case (state)
         IDLE: begin
            // reset gating keeps imply_clear low while reset is held
            imply_clear = start & reset;
         end
         SCAN: begin
            if (!trace_empty) begin
               vs_write    = 1'b1;
               vs_unassign = 1'b1;
               vs_var      = trace_var;
               trace_pop   = 1'b1;
            end
         end
         FLIP: begin
            if (!ds_empty) begin
               vs_write       = 1'b1;
               vs_var         = lat_var;
               vs_val         = ~lat_val;
               trace_push     = 1'b1;
               trace_type_out = ENTRY_FORCED;
               trace_val_out  = ~lat_val;
               trace_var_out  = lat_var;
               ds_pop         = 1'b1;
               dec_write      = 1'b1;
               dec_back_idx   = ds_dec_idx;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_backtrack_unit.sv
// Directed bench for backtrack_unit with a behavioural trace stack model.
module tb_backtrack_unit;

   localparam int W = 8;

   typedef struct packed {
      logic         typ;
      logic         val;
      logic [W-1:0] v;
   } entry_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         busy, done, unsat;
   logic         trace_empty = 1'b1;
   logic         trace_type  = 1'b0;
   logic         trace_val   = 1'b0;
   logic [W-1:0] trace_var   = '0;
   logic         trace_pop, trace_push, trace_type_out, trace_val_out;
   logic [W-1:0] trace_var_out;
   logic         vs_write, vs_val, vs_unassign;
   logic [W-1:0] vs_var;
   logic         ds_empty   = 1'b1;
   logic [W-1:0] ds_dec_idx = '0;
   logic         ds_pop, dec_write;
   logic [W-1:0] dec_back_idx;
   logic         imply_clear;
   logic [W:0]   pop_count;

   int errors = 0;
   int checks = 0;

   backtrack_unit #(.MAX_VARS_BITS(W)) dut (
      .clock(clock), .reset(reset), .start(start),
      .busy(busy), .done(done), .unsat(unsat),
      .trace_empty(trace_empty), .trace_type(trace_type),
      .trace_val(trace_val), .trace_var(trace_var),
      .trace_pop(trace_pop), .trace_push(trace_push),
      .trace_type_out(trace_type_out), .trace_val_out(trace_val_out),
      .trace_var_out(trace_var_out),
      .vs_write(vs_write), .vs_val(vs_val), .vs_unassign(vs_unassign),
      .vs_var(vs_var),
      .ds_empty(ds_empty), .ds_dec_idx(ds_dec_idx), .ds_pop(ds_pop),
      .dec_write(dec_write), .dec_back_idx(dec_back_idx),
      .imply_clear(imply_clear), .pop_count(pop_count)
   );

   always #5 clock = ~clock;

   // trace stack model and per-operation observation log
   entry_t       stk[$];
   logic [W-1:0] un_q[$];
   int           cyc = 0, start_cyc = 0;
   int           done_cnt, unsat_pulses, done_cyc, wr_cnt, push_cnt;
   int           dec_cnt, ds_pop_cnt, ic_cnt, busy_cnt;
   int           overlap_cnt = 0, orphan_unsat = 0;
   logic         done_unsat, wr_val, s_pop, s_push;
   logic [W-1:0] wr_var, dec_idx;
   entry_t       push_e, s_push_e;

   task automatic clear_log();
      un_q.delete();
      done_cnt = 0; unsat_pulses = 0; done_cyc = -1; wr_cnt = 0;
      push_cnt = 0; dec_cnt = 0; ds_pop_cnt = 0; ic_cnt = 0; busy_cnt = 0;
      done_unsat = 1'b0; wr_val = 1'b0; wr_var = '0; dec_idx = '0;
      push_e = '0;
   endtask

   task automatic refresh_top();
      trace_empty = (stk.size() == 0);
      trace_type  = (stk.size() != 0) ? stk[$].typ : 1'b0;
      trace_val   = (stk.size() != 0) ? stk[$].val : 1'b0;
      trace_var   = (stk.size() != 0) ? stk[$].v   : '0;
   endtask

   always @(negedge clock) begin
      s_pop    = trace_pop;
      s_push   = trace_push;
      s_push_e = '{typ: trace_type_out, val: trace_val_out, v: trace_var_out};
      if (trace_pop && trace_push) overlap_cnt++;
      if (unsat && !done) orphan_unsat++;
      if (busy) busy_cnt++;
      if (imply_clear) ic_cnt++;
      if (vs_write && vs_unassign) un_q.push_back(vs_var);
      if (vs_write && !vs_unassign) begin
         wr_cnt++; wr_var = vs_var; wr_val = vs_val;
      end
      if (trace_push) begin push_cnt++; push_e = s_push_e; end
      if (dec_write) begin dec_cnt++; dec_idx = dec_back_idx; end
      if (ds_pop) ds_pop_cnt++;
      if (unsat) unsat_pulses++;
      if (done) begin
         done_cnt++; done_cyc = cyc - start_cyc; done_unsat = unsat;
      end
   end

   always @(posedge clock) begin
      cyc++;
      if (s_pop && stk.size() != 0) void'(stk.pop_back());
      if (s_push) stk.push_back(s_push_e);
      s_pop  = 1'b0;
      s_push = 1'b0;
      trace_empty <= (stk.size() == 0);
      trace_type  <= (stk.size() != 0) ? stk[$].typ : 1'b0;
      trace_val   <= (stk.size() != 0) ? stk[$].val : 1'b0;
      trace_var   <= (stk.size() != 0) ? stk[$].v   : '0;
   end

   task automatic load(input entry_t e0, input entry_t e1, input entry_t e2,
                       input entry_t e3, input int n);
      @(posedge clock); #1;
      stk.delete();
      if (n > 0) stk.push_back(e0);
      if (n > 1) stk.push_back(e1);
      if (n > 2) stk.push_back(e2);
      if (n > 3) stk.push_back(e3);
      refresh_top();
   endtask

   task automatic run_op(input int hold);
      @(posedge clock); #1;
      clear_log();
      start = 1'b1;
      start_cyc = cyc;
      for (int k = 0; k < hold; k++) begin
         @(posedge clock); #1;
      end
      start = 1'b0;
      for (int k = 0; k < 30 && done_cnt == 0; k++) @(negedge clock);
      checks++;
      if (done_cnt == 0) begin
         errors++; $display("FAIL done_timeout: no done within 30 cycles");
      end
      repeat (4) @(posedge clock);
      #1;
   endtask

   task automatic expect_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({busy, done, unsat, trace_pop, trace_push, vs_write, ds_pop,
           dec_write, imply_clear, pop_count} !== '0) begin
         errors++; $display("FAIL reset_outputs: some output nonzero during reset");
      end
      start = 1'b1; #1;
      checks++;
      if (imply_clear !== 1'b0) begin
         errors++; $display("FAIL reset_imply_clear: got %b expected 0", imply_clear);
      end
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      expect_int("idle_busy", busy, 0);
   endtask

   task automatic test_decision_flip();
      ds_empty = 1'b0; ds_dec_idx = 8'd2;
      load('{1'b0, 1'b1, 8'd3}, '{1'b1, 1'b0, 8'd5}, '{1'b1, 1'b1, 8'd7},
           '0, 3);
      run_op(1);
      expect_int("flip_unassign_n", un_q.size(), 3);
      if (un_q.size() == 3) begin
         expect_int("flip_unassign0", un_q[0], 7);
         expect_int("flip_unassign1", un_q[1], 5);
         expect_int("flip_unassign2", un_q[2], 3);
      end
      expect_int("flip_wr_cnt", wr_cnt, 1);
      expect_int("flip_wr_var", wr_var, 3);
      expect_int("flip_wr_val", wr_val, 0);
      expect_int("flip_push_cnt", push_cnt, 1);
      expect_int("flip_push_entry", push_e, {1'b1, 1'b0, 8'd3});
      expect_int("flip_dec_idx", dec_idx, 2);
      expect_int("flip_ds_pop", ds_pop_cnt, 1);
      expect_int("flip_done_cyc", done_cyc, 5);
      expect_int("flip_unsat", done_unsat, 0);
      expect_int("flip_pop_count", pop_count, 3);
      expect_int("flip_imply_clear", ic_cnt, 1);
      expect_int("flip_busy_cycles", busy_cnt, 5);
      expect_int("flip_stack_size", stk.size(), 1);
   endtask

   task automatic test_empty_trace();
      ds_empty = 1'b0;
      load('0, '0, '0, '0, 0);
      run_op(1);
      expect_int("empty_done_cyc", done_cyc, 2);
      expect_int("empty_unsat", done_unsat, 1);
      expect_int("empty_unassign_n", un_q.size(), 0);
      expect_int("empty_wr_cnt", wr_cnt, 0);
      expect_int("empty_pop_count", pop_count, 0);
      expect_int("empty_busy_cycles", busy_cnt, 2);
   endtask

   task automatic test_all_forced();
      ds_empty = 1'b0;
      load('{1'b1, 1'b1, 8'd1}, '{1'b1, 1'b0, 8'd2}, '0, '0, 2);
      run_op(1);
      expect_int("forced_unassign_n", un_q.size(), 2);
      if (un_q.size() == 2) begin
         expect_int("forced_unassign0", un_q[0], 2);
         expect_int("forced_unassign1", un_q[1], 1);
      end
      expect_int("forced_done_cyc", done_cyc, 4);
      expect_int("forced_unsat", done_unsat, 1);
      expect_int("forced_push_cnt", push_cnt, 0);
      expect_int("forced_pop_count", pop_count, 2);
   endtask

   task automatic test_held_start();
      ds_empty = 1'b0; ds_dec_idx = 8'd4;
      load('{1'b0, 1'b0, 8'd9}, '0, '0, '0, 1);
      run_op(4);
      repeat (4) @(posedge clock);
      #1;
      expect_int("held_done_cnt", done_cnt, 1);
      expect_int("held_imply_clear", ic_cnt, 1);
      expect_int("held_done_cyc", done_cyc, 3);
      expect_int("held_push_entry", push_e, {1'b1, 1'b1, 8'd9});
      expect_int("held_dec_idx", dec_idx, 4);
      expect_int("held_pop_count", pop_count, 1);
   endtask

   task automatic test_reset_mid();
      ds_empty = 1'b0; ds_dec_idx = 8'd1;
      load('{1'b0, 1'b1, 8'd4}, '{1'b1, 1'b0, 8'd3}, '{1'b1, 1'b1, 8'd2},
           '{1'b1, 1'b0, 8'd1}, 4);
      @(posedge clock); #1;
      clear_log();
      start = 1'b1; start_cyc = cyc;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, trace_pop, vs_write, vs_unassign, vs_var, pop_count} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: busy=%b pop=%b vs_write=%b pop_count=%0d expected all 0",
                  busy, trace_pop, vs_write, pop_count);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (8) @(posedge clock);
      #1;
      expect_int("midreset_no_done", done_cnt, 0);
      load('{1'b0, 1'b0, 8'd5}, '0, '0, '0, 1);
      run_op(1);
      expect_int("after_reset_done_cyc", done_cyc, 3);
      expect_int("after_reset_push", push_e, {1'b1, 1'b1, 8'd5});
      expect_int("after_reset_pop_count", pop_count, 1);
   endtask

   task automatic test_decide_no_decider();
      ds_empty = 1'b1;
      load('{1'b0, 1'b1, 8'd6}, '0, '0, '0, 1);
      run_op(1);
      expect_int("nodec_unassign_n", un_q.size(), 1);
      if (un_q.size() == 1) expect_int("nodec_unassign0", un_q[0], 6);
      expect_int("nodec_done_cyc", done_cyc, 3);
      expect_int("nodec_unsat", done_unsat, 1);
      expect_int("nodec_push_cnt", push_cnt, 0);
      expect_int("nodec_wr_cnt", wr_cnt, 0);
      expect_int("nodec_ds_pop", ds_pop_cnt, 0);
      expect_int("nodec_dec_write", dec_cnt, 0);
   endtask

   initial begin
      clear_log();
      test_reset();
      test_decision_flip();
      test_empty_trace();
      test_all_forced();
      test_held_start();
      test_reset_mid();
      test_decide_no_decider();
      expect_int("pop_push_overlap", overlap_cnt, 0);
      expect_int("unsat_without_done", orphan_unsat, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/backtrack_unit.md
BACKTRACK_UNIT -- requirements
Module: backtrack_unit

Interface
REQ-001 Parameter: MAX_VARS_BITS, default `MAX_VARS_BITS from sysdefs.svh, width of a variable or decider index.
REQ-002 Timing: the block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  rising-edge system clock.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 start  in  1  single-cycle request from control on a conflict.
REQ-006 busy  out  1  high from the cycle after start acceptance through the final cycle.
REQ-007 done  out  1  single-cycle completion pulse.
REQ-008 unsat  out  1  single-cycle pulse, coincident with done, when no decision remains.
REQ-009 trace_empty, trace_type, trace_val  in  1 each  trace stack top; type 0 = decide, 1 = forced.
REQ-010 trace_var  in  MAX_VARS_BITS  trace stack top variable.
REQ-011 trace_pop, trace_push, trace_type_out, trace_val_out  out  1 each  trace stack controls and push data.
REQ-012 trace_var_out  out  MAX_VARS_BITS  trace push variable.
REQ-013 vs_write, vs_val, vs_unassign  out  1 each  var_state write port.
REQ-014 vs_var  out  MAX_VARS_BITS  var_state write variable.
REQ-015 ds_empty  in  1; ds_dec_idx  in  MAX_VARS_BITS  decider stack top.
REQ-016 ds_pop  out  1  decider stack pop.
REQ-017 dec_write  out  1; dec_back_idx  out  MAX_VARS_BITS  decider rewind.
REQ-018 imply_clear  out  1  synchronous clear of the imply stack.
REQ-019 pop_count  out  MAX_VARS_BITS+1  trace entries removed in the last operation.

Function
REQ-020 FSM states SHALL be IDLE, SCAN, FLIP, DONE and FAIL.
REQ-021 Stack semantics: the top SHALL be valid combinationally when not empty, and a pop or push SHALL take effect at the next edge.
REQ-022 IDLE: start=1 SHALL assert imply_clear that cycle, zero pop_count, and go to SCAN; start outside IDLE SHALL be ignored.
REQ-023 SCAN, trace_empty=1: the block SHALL go to FAIL with no write or pop.
REQ-024 SCAN, trace_type=1: the block SHALL assert vs_write (vs_var=trace_var, vs_unassign=1) and trace_pop, increment pop_count, and stay in SCAN.
REQ-025 SCAN, trace_type=0: the block SHALL do the same unassign/pop/increment, latch trace_var and trace_val, and go to FLIP.
REQ-026 FLIP, ds_empty=0: the block SHALL assert vs_write (latched var, vs_val=~latched val, vs_unassign=0), trace_push (type 1, ~val, var), ds_pop, and dec_write with dec_back_idx=ds_dec_idx, then go to DONE.
REQ-027 FLIP, ds_empty=1: the block SHALL go to FAIL with no write.
REQ-028 DONE SHALL pulse done, and FAIL SHALL pulse done and unsat; both SHALL then go to IDLE.
REQ-029 Latency: with N forced entries above the newest decision, done SHALL assert N+3 cycles after the start cycle; with an empty trace, done and unsat SHALL assert 2 cycles after it.
REQ-030 trace_pop and trace_push SHALL never be asserted in the same cycle.
REQ-031 pop_count SHALL NOT wrap, since trace depth is at most 2^MAX_VARS_BITS.
REQ-032 pop_count SHALL hold its value until the next accepted start.
REQ-033 All strobes not listed for a state SHALL be 0.

Reset
REQ-034 reset low SHALL immediately force IDLE and drive every output, including pop_count and latched var/val, to 0.
REQ-035 Reset mid-operation SHALL abandon the operation with no done pulse.

Structure
REQ-036 The bt_state_t enum and the entry type encoding (DECIDE=0, FORCED=1) SHALL live in the shared sysdefs package.
REQ-037 The block SHALL be a single flat module with no sub-modules.

Verification
REQ-038 Scenario: trace={v3 dec 1, v5 forced 0, v7 forced 1} (top last), ds_dec_idx=2, start -> v7 and v5 unassigned, then v3 unassigned; v3 written 0; push (forced, 0, v3); dec_back_idx=2; done at cycle 5; pop_count=3.
REQ-039 Scenario: empty trace, start -> done and unsat at cycle 2; no vs_write.
REQ-040 Scenario: trace={v1 forced 1, v2 forced 0} -> both unassigned, then FAIL; unsat at cycle 4.
REQ-041 Scenario: start held 4 cycles -> exactly one operation and one done pulse.
REQ-042 Scenario: reset low during SCAN -> outputs 0 in the same cycle; no done; a later start behaves normally.
REQ-043 Scenario: single decision on top with ds_empty=1 -> v unassigned, then FAIL; no trace_push.
